// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared helpers for the one-shot timer
//
// Purpose : holds the counter width derivation used by the timer core.
// Contents: timer_cw(n) returns the number of bits needed to hold 0..n.
package timer_pkg;

  function automatic int timer_cw(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/timer_edge_det.sv
// rtl/timer_edge_det.sv - rising-edge detector for the timer trigger
//
// Purpose : registers the previous trigger level and flags a 0->1 transition.
// Ports   :
//   clk  in   system clock, rising-edge active
//   rst  in   asynchronous active-high reset, clears the history flop
//   trg  in   trigger level, synchronous to clk
//   rise out  combinational, high in the cycle where trg is 1 and was 0
module timer_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic trg,
  output logic rise
);

  logic trg_q;

  // Clearing trg_q in reset makes a trigger already high at reset release
  // count as a fresh edge on the first clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trg_q <= 1'b0;
    end else begin
      trg_q <= trg;
    end
  end

  assign rise = trg & ~trg_q;

endmodule

// File: rtl/timer.sv
// rtl/timer.sv - digital one-shot timer with selectable retrigger policy
//
// Purpose : a trigger rising edge drives OUT high for exactly N clock cycles.
//           MODE=0 ignores triggers during the pulse, MODE=1 restarts the count.
// Ports   :
//   CLK     in   system clock, rising-edge active
//   R       in   asynchronous active-high reset
//   TRG_ONE in   trigger, synchronous to CLK; the rising edge is the event
//   MODE    in   0 = non-retriggerable, 1 = retriggerable
//   OUT     out  timer pulse, driven straight from a flop
module timer
  import timer_pkg::*;
#(
  parameter int N = 100
) (
  input  logic CLK,
  input  logic R,
  input  logic TRG_ONE,
  input  logic MODE,
  output logic OUT
);

  localparam int            CW       = timer_cw(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic          rise;
  logic [CW-1:0] cnt;

  timer_edge_det u_edge_det (
    .clk  (CLK),
    .rst  (R),
    .trg  (TRG_ONE),
    .rise (rise)
  );

  // OUT doubles as the state: 0 = idle, 1 = active. cnt counts cycles
  // already spent high since the start or the last restart.
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      OUT <= 1'b0;
      cnt <= '0;
    end else if (!OUT) begin
      if (rise) begin
        OUT <= 1'b1;
        cnt <= '0;
      end
    end else if (rise && MODE) begin
      // Restart wins even on the final cycle.
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      OUT <= 1'b0;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_timer.sv
// tb/tb_timer.sv - directed self-checking bench for the one-shot timer
module tb_timer;

  logic CLK = 1'b0;
  logic R;
  logic TRG_ONE;
  logic MODE;
  logic OUT;

  int pass_cnt = 0;
  int total_cnt = 0;

  timer #(.N(100)) dut (
    .CLK     (CLK),
    .R       (R),
    .TRG_ONE (TRG_ONE),
    .MODE    (MODE),
    .OUT     (OUT)
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Apply a one-cycle trigger; returns just after the sampling edge (index 0).
  task automatic fire();
    TRG_ONE = 1'b1;
    step();
    TRG_ONE = 1'b0;
  endtask

  task automatic test_reset();
    R = 1'b1; TRG_ONE = 1'b0; MODE = 1'b0;
    step();
    total_cnt++;
    if (OUT !== 1'b0) $display("FAIL reset_out_during got=%b want=0", OUT); else pass_cnt++;
    total_cnt++;
    if (dut.cnt !== 7'd0) $display("FAIL reset_cnt_during got=%0d want=0", dut.cnt); else pass_cnt++;
    R = 1'b0;
    steps(2);
    total_cnt++;
    if (OUT !== 1'b0) $display("FAIL reset_out_after got=%b want=0", OUT); else pass_cnt++;
    total_cnt++;
    if (dut.cnt !== 7'd0) $display("FAIL reset_cnt_after got=%0d want=0", dut.cnt); else pass_cnt++;
    // Reset mid-pulse must drop OUT without a clock edge.
    fire();
    steps(10);
    total_cnt++;
    if (OUT !== 1'b1) $display("FAIL reset_mid_pre got=%b want=1", OUT); else pass_cnt++;
    #2 R = 1'b1;
    #1;
    total_cnt++;
    if (OUT !== 1'b0) $display("FAIL reset_mid_async got=%b want=0", OUT); else pass_cnt++;
    step();
    R = 1'b0;
    steps(2);
  endtask

  task automatic test_single();
    int w;
    int highs;
    MODE = 1'b0;
    fire();
    total_cnt++;
    if (OUT !== 1'b1) $display("FAIL single_latency got=%b want=1", OUT); else pass_cnt++;
    total_cnt++;
    if (dut.cnt !== 7'd0) $display("FAIL single_cnt0 got=%0d want=0", dut.cnt); else pass_cnt++;
    w = 1;
    while (OUT === 1'b1 && w < 1000) begin
      step();
      if (OUT === 1'b1) w++;
    end
    total_cnt++;
    if (w !== 100) $display("FAIL single_width got=%0d want=100", w); else pass_cnt++;
    highs = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (OUT !== 1'b0) highs++;
    end
    total_cnt++;
    if (highs !== 0) $display("FAIL single_quiet got=%0d want=0", highs); else pass_cnt++;
  endtask

  task automatic test_ignore();
    MODE = 1'b0;
    fire();
    steps(49);
    TRG_ONE = 1'b1;
    step();
    TRG_ONE = 1'b0;
    total_cnt++;
    if (dut.cnt !== 7'd50) $display("FAIL ignore_cnt got=%0d want=50", dut.cnt); else pass_cnt++;
    steps(49);
    total_cnt++;
    if (OUT !== 1'b1) $display("FAIL ignore_high99 got=%b want=1", OUT); else pass_cnt++;
    step();
    total_cnt++;
    if (OUT !== 1'b0) $display("FAIL ignore_low100 got=%b want=0", OUT); else pass_cnt++;
    steps(5);
  endtask

  task automatic test_retrigger();
    int lows;
    MODE = 1'b1;
    lows = 0;
    fire();
    for (int i = 1; i < 50; i++) begin
      step();
      if (OUT !== 1'b1) lows++;
    end
    TRG_ONE = 1'b1;
    step();
    TRG_ONE = 1'b0;
    total_cnt++;
    if (dut.cnt !== 7'd0) $display("FAIL retrig_cnt got=%0d want=0", dut.cnt); else pass_cnt++;
    if (OUT !== 1'b1) lows++;
    for (int i = 51; i < 150; i++) begin
      step();
      if (OUT !== 1'b1) lows++;
    end
    total_cnt++;
    if (lows !== 0) $display("FAIL retrig_continuous got=%0d lows want=0", lows); else pass_cnt++;
    step();
    total_cnt++;
    if (OUT !== 1'b0) $display("FAIL retrig_low150 got=%b want=0", OUT); else pass_cnt++;
    MODE = 1'b0;
    steps(5);
  endtask

  task automatic test_held();
    int highs;
    int rises;
    logic prev;
    MODE = 1'b0;
    highs = 0; rises = 0; prev = OUT;
    TRG_ONE = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (OUT === 1'b1) highs++;
      if (OUT === 1'b1 && prev === 1'b0) rises++;
      prev = OUT;
    end
    TRG_ONE = 1'b0;
    total_cnt++;
    if (highs !== 100) $display("FAIL held_width got=%0d want=100", highs); else pass_cnt++;
    total_cnt++;
    if (rises !== 1) $display("FAIL held_pulses got=%0d want=1", rises); else pass_cnt++;
    steps(5);
    // Trigger already high when reset releases.
    R = 1'b1;
    TRG_ONE = 1'b1;
    step();
    R = 1'b0;
    step();
    total_cnt++;
    if (OUT !== 1'b1) $display("FAIL held_rst_release got=%b want=1", OUT); else pass_cnt++;
    total_cnt++;
    if (dut.cnt !== 7'd0) $display("FAIL held_rst_cnt got=%0d want=0", dut.cnt); else pass_cnt++;
    TRG_ONE = 1'b0;
    steps(100);
    total_cnt++;
    if (OUT !== 1'b0) $display("FAIL held_rst_end got=%b want=0", OUT); else pass_cnt++;
    steps(3);
  endtask

  task automatic test_boundary();
    int highs;
    // MODE=1: edge sampled when cnt==99 restarts.
    MODE = 1'b1;
    fire();
    steps(99);
    total_cnt++;
    if (dut.cnt !== 7'd99) $display("FAIL bnd1_cnt99 got=%0d want=99", dut.cnt); else pass_cnt++;
    TRG_ONE = 1'b1;
    step();
    TRG_ONE = 1'b0;
    total_cnt++;
    if (OUT !== 1'b1) $display("FAIL bnd1_stay got=%b want=1", OUT); else pass_cnt++;
    total_cnt++;
    if (dut.cnt !== 7'd0) $display("FAIL bnd1_cnt got=%0d want=0", dut.cnt); else pass_cnt++;
    steps(99);
    total_cnt++;
    if (OUT !== 1'b1) $display("FAIL bnd1_high199 got=%b want=1", OUT); else pass_cnt++;
    step();
    total_cnt++;
    if (OUT !== 1'b0) $display("FAIL bnd1_low200 got=%b want=0", OUT); else pass_cnt++;
    steps(5);
    // MODE=0: the pulse ends and the coincident edge is dropped.
    MODE = 1'b0;
    fire();
    steps(99);
    TRG_ONE = 1'b1;
    step();
    total_cnt++;
    if (OUT !== 1'b0) $display("FAIL bnd0_fall got=%b want=0", OUT); else pass_cnt++;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (OUT !== 1'b0) highs++;
    end
    TRG_ONE = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (OUT !== 1'b0) highs++;
    end
    total_cnt++;
    if (highs !== 0) $display("FAIL bnd0_no_pulse got=%0d want=0", highs); else pass_cnt++;
  endtask

  initial begin
    R = 1'b1;
    TRG_ONE = 1'b0;
    MODE = 1'b0;
    test_reset();
    test_single();
    test_ignore();
    test_retrigger();
    test_held();
    test_boundary();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
